// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave (MSB first) running entirely on clk: oversampled pins, command/address/data
// framing onto a register-file port with single-cycle strobes and burst auto-increment.
module spi_slave_sync #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_RD      = 8'hC1,
    parameter logic [7:0]  CMD_RDB     = 8'hC5,
    parameter logic [7:0]  CMD_WR      = 8'hC2,
    parameter logic [7:0]  CMD_WRB     = 8'hCA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_we,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              busy,
    output logic              cmd_err
);
    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                      : ((DATA_W > 8) ? DATA_W : 8);
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {ST_IGNORE, ST_CMD, ST_ADDR, ST_DATA, ST_HOLD} state_t;

    state_t r_state, w_next_state;

    logic [SYNC_STAGES-1:0] r_csn_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_sclk_prev;
    logic [6:0]             r_cmd_sh;
    logic [7:0]             r_cmd;
    logic [DATA_W-2:0]      r_data_sh;
    logic [DATA_W-1:0]      r_tx;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_din;
    logic                   r_we, r_re, r_oe, r_err;

    logic              w_csn_s, w_sclk_s, w_mosi_s, w_rise, w_fall;
    logic [7:0]        w_cmd_byte;
    logic [DATA_W-1:0] w_data_word;
    logic              w_cmd_known, w_is_read, w_is_burst;
    logic              w_last_cmd, w_last_addr, w_last_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn_sync  <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk_s & ~r_sclk_prev;
    assign w_fall      = ~w_sclk_s & r_sclk_prev;

    assign w_cmd_byte  = {r_cmd_sh, w_mosi_s};
    assign w_data_word = {r_data_sh, w_mosi_s};
    assign w_cmd_known = (w_cmd_byte == CMD_RD) || (w_cmd_byte == CMD_RDB) ||
                         (w_cmd_byte == CMD_WR) || (w_cmd_byte == CMD_WRB);
    assign w_is_read   = (r_cmd == CMD_RD)  || (r_cmd == CMD_RDB);
    assign w_is_burst  = (r_cmd == CMD_RDB) || (r_cmd == CMD_WRB);
    assign w_last_cmd  = (r_bit_cnt == CNT_W'(7));
    assign w_last_addr = (r_bit_cnt == CNT_W'(ADDR_W - 1));
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IGNORE;
        else     r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state so every path assigns it and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (w_csn_s) begin
            w_next_state = ST_CMD;
        end else begin
            case (r_state)
                ST_CMD:  if (w_rise && w_last_cmd)  w_next_state = w_cmd_known ? ST_ADDR : ST_IGNORE;
                ST_ADDR: if (w_rise && w_last_addr) w_next_state = ST_DATA;
                ST_DATA: if (w_rise && w_last_data && !w_is_burst) w_next_state = ST_HOLD;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_sh  <= '0;
            r_cmd     <= '0;
            r_data_sh <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_oe      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_re  <= 1'b0;
            r_err <= 1'b0;
            if (w_csn_s) begin
                // Frame boundary: anything partially shifted in is dropped without a strobe.
                r_cmd_sh  <= '0;
                r_data_sh <= '0;
                r_tx      <= '0;
                r_bit_cnt <= '0;
                r_oe      <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD: if (w_rise) begin
                        r_cmd_sh <= w_cmd_byte[6:0];
                        if (w_last_cmd) begin
                            r_bit_cnt <= '0;
                            r_cmd     <= w_cmd_byte;
                            r_err     <= ~w_cmd_known;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        r_addr <= ADDR_W'({r_addr, w_mosi_s});
                        if (w_last_addr) begin
                            r_bit_cnt <= '0;
                            r_re      <= w_is_read;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        // A load lands between the word's last rise and the next fall, so it never meets a shift.
                        if (r_re) begin
                            r_tx <= rf_dout;
                            r_oe <= 1'b1;
                        end else if (w_fall && r_bit_cnt != '0) begin
                            r_tx <= r_tx << 1;
                        end
                        if (r_we) r_addr <= r_addr + ADDR_W'(1);
                        if (w_rise) begin
                            r_data_sh <= w_data_word[DATA_W-2:0];
                            if (w_last_data) begin
                                r_bit_cnt <= '0;
                                if (!w_is_read) begin
                                    r_din <= w_data_word;
                                    r_we  <= 1'b1;
                                end else if (w_is_burst) begin
                                    r_addr <= r_addr + ADDR_W'(1);
                                    r_re   <= 1'b1;
                                end else begin
                                    r_tx <= '0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign miso    = r_tx[DATA_W-1];
    assign miso_oe = r_oe;
    assign rf_addr = r_addr;
    assign rf_din  = r_din;
    assign rf_we   = r_we;
    assign rf_re   = r_re;
    assign cmd_err = r_err;
    assign busy    = ~w_csn_s && (r_state != ST_IGNORE);

endmodule
